// File: rtl/cu_lane_array_accum_if.sv
// Lane-side and drain-side bundle of the lane array accumulator.
// slave: the accumulator; master: lanes plus writeback stage.
interface cu_lane_array_accum_if #(
    parameter int LANES  = 4,
    parameter int PROD_W = 16,
    parameter int ACC_W  = 32
);
    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

    logic                     sub_chunk_start_o;
    logic [LANES-1:0]         lane_acc_val_i;
    logic [LANES*PROD_W-1:0]  lane_acc_dat_i;
    logic [LANES-1:0]         lane_sub_end_i;
    logic                     out_valid_o;
    logic                     out_ready_i;
    logic [LW-1:0]            out_lane_o;
    logic [ACC_W-1:0]         out_dat_o;

    modport slave (
        output sub_chunk_start_o,
        input  lane_acc_val_i,
        input  lane_acc_dat_i,
        input  lane_sub_end_i,
        output out_valid_o,
        input  out_ready_i,
        output out_lane_o,
        output out_dat_o
    );

    modport master (
        input  sub_chunk_start_o,
        output lane_acc_val_i,
        output lane_acc_dat_i,
        output lane_sub_end_i,
        input  out_valid_o,
        output out_ready_i,
        input  out_lane_o,
        input  out_dat_o
    );
endinterface

// File: rtl/cu_lane_array_accum.sv
// Sequences LANES compute lanes through N sub-chunks, accumulates their
// partial sums into banked saturating accumulators and drains one bank.
// Ports: clk_i/rst_i (sync, active high), start_i + cfg_* job setup,
// bus (lane sums in, drain beats out), busy_o, done_o, protocol_err_o.
module cu_lane_array_accum #(
    parameter int LANES         = 4,
    parameter int PROD_W        = 16,
    parameter int ACC_W         = 32,
    parameter int BUF_NUM       = 4,
    parameter int SUB_CHUNK_MAX = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_i,
    input  logic                             start_i,
    input  logic [$clog2(SUB_CHUNK_MAX):0]   cfg_sub_chunks_i,
    input  logic [$clog2(BUF_NUM)-1:0]       cfg_buf_sel_i,
    input  logic                             cfg_clear_i,
    input  logic                             cfg_relu_i,
    cu_lane_array_accum_if.slave             bus,
    output logic                             busy_o,
    output logic                             done_o,
    output logic                             protocol_err_o
);
    localparam int SCW = $clog2(SUB_CHUNK_MAX) + 1;
    localparam int BW  = $clog2(BUF_NUM);
    localparam int LW  = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [SCW-1:0]          nsub_q, sub_cnt_q;
    logic [BW-1:0]           buf_q;
    logic                    relu_q;
    logic [LANES-1:0]        end_q, end_d;
    logic                    err_q, err_d;
    logic [LW-1:0]           lane_q;
    logic                    out_valid_q, done_q;
    logic [ACC_W-1:0]        out_dat_q;
    logic signed [ACC_W-1:0] bank_q [LANES][BUF_NUM];
    logic signed [ACC_W-1:0] bank_d [LANES][BUF_NUM];
    logic                    beat, last_beat, sub_done;
    logic [SCW-1:0]          nsub_cfg;

    function automatic logic signed [ACC_W-1:0] sat_add(
        input logic signed [ACC_W-1:0]  a,
        input logic signed [PROD_W-1:0] b
    );
        logic signed [ACC_W:0] s;
        s = {a[ACC_W-1], a} + {{(ACC_W+1-PROD_W){b[PROD_W-1]}}, b};
        // Top two bits disagree only on overflow; clamp toward the sign.
        if (s[ACC_W] != s[ACC_W-1])
            return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                            : {1'b0, {(ACC_W-1){1'b1}}};
        return s[ACC_W-1:0];
    endfunction

    function automatic logic [ACC_W-1:0] relu_f(input logic [ACC_W-1:0] x);
        return (relu_q && x[ACC_W-1]) ? '0 : x;
    endfunction

    assign beat      = (state_q == DRAIN) && out_valid_q && bus.out_ready_i;
    assign last_beat = beat && (lane_q == LW'(LANES-1));

    always_comb begin
        if (cfg_sub_chunks_i == '0)
            nsub_cfg = SCW'(1);
        else if (cfg_sub_chunks_i > SCW'(SUB_CHUNK_MAX))
            nsub_cfg = SCW'(SUB_CHUNK_MAX);
        else
            nsub_cfg = cfg_sub_chunks_i;
    end

    always_comb begin
        state_d  = state_q;
        bank_d   = bank_q;
        end_d    = end_q;
        err_d    = err_q;
        sub_done = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = START;
                    if (cfg_clear_i)
                        for (int l = 0; l < LANES; l++)
                            bank_d[l][cfg_buf_sel_i] = '0;
                end
            end
            START: begin
                end_d   = '0;
                state_d = RUN;
            end
            RUN: begin
                for (int l = 0; l < LANES; l++) begin
                    if (bus.lane_acc_val_i[l]) begin
                        if (end_q[l])
                            err_d = 1'b1;
                        else
                            bank_d[l][buf_q] = sat_add(bank_q[l][buf_q],
                                bus.lane_acc_dat_i[l*PROD_W +: PROD_W]);
                    end
                end
                end_d = end_q | bus.lane_sub_end_i;
                if (&end_d) begin
                    sub_done = 1'b1;
                    state_d  = (sub_cnt_q + SCW'(1) == nsub_q) ? DRAIN : START;
                end
            end
            DRAIN: begin
                if (last_beat)
                    state_d = IDLE;
            end
        endcase
        // Lane activity is only meaningful while a sub-chunk is running.
        if (state_q != RUN &&
            (|bus.lane_acc_val_i || |bus.lane_sub_end_i))
            err_d = 1'b1;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            nsub_q      <= '0;
            sub_cnt_q   <= '0;
            buf_q       <= '0;
            relu_q      <= 1'b0;
            end_q       <= '0;
            err_q       <= 1'b0;
            lane_q      <= '0;
            out_valid_q <= 1'b0;
            out_dat_q   <= '0;
            done_q      <= 1'b0;
            for (int l = 0; l < LANES; l++)
                for (int b = 0; b < BUF_NUM; b++)
                    bank_q[l][b] <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            end_q   <= end_d;
            err_q   <= err_d;
            done_q  <= 1'b0;
            if (state_q == IDLE && start_i) begin
                nsub_q    <= nsub_cfg;
                sub_cnt_q <= '0;
                buf_q     <= cfg_buf_sel_i;
                relu_q    <= cfg_relu_i;
            end
            if (sub_done)
                sub_cnt_q <= sub_cnt_q + SCW'(1);
            // Lane 0 must see this cycle's final accumulation.
            if (state_q == RUN && state_d == DRAIN) begin
                out_valid_q <= 1'b1;
                lane_q      <= '0;
                out_dat_q   <= relu_f(bank_d[0][buf_q]);
            end
            if (last_beat) begin
                out_valid_q <= 1'b0;
                lane_q      <= '0;
                out_dat_q   <= '0;
                done_q      <= 1'b1;
            end else if (beat) begin
                lane_q    <= lane_q + LW'(1);
                out_dat_q <= relu_f(bank_q[lane_q + LW'(1)][buf_q]);
            end
        end
    end

    assign bus.sub_chunk_start_o = (state_q == START);
    assign bus.out_valid_o       = out_valid_q;
    assign bus.out_lane_o        = lane_q;
    assign bus.out_dat_o         = out_dat_q;
    assign busy_o                = (state_q != IDLE);
    assign done_o                = done_q;
    assign protocol_err_o        = err_q;
endmodule

// File: tb/tb_cu_lane_array_accum.sv
// Self-checking bench for cu_lane_array_accum against a per-bank
// saturating-sum model (LANES=4, PROD_W=8, ACC_W=16).
module tb_cu_lane_array_accum;
    localparam int LANES   = 4;
    localparam int PROD_W  = 8;
    localparam int ACC_W   = 16;
    localparam int BUF_NUM = 4;
    localparam int SCM     = 16;
    localparam int AMAX    = 32767;
    localparam int AMIN    = -32768;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] cfg_sub;
    logic [1:0] cfg_buf;
    logic       cfg_clr;
    logic       cfg_relu;
    logic       busy, done, perr;

    cu_lane_array_accum_if #(
        .LANES(LANES), .PROD_W(PROD_W), .ACC_W(ACC_W)
    ) bus ();

    cu_lane_array_accum #(
        .LANES(LANES), .PROD_W(PROD_W), .ACC_W(ACC_W),
        .BUF_NUM(BUF_NUM), .SUB_CHUNK_MAX(SCM)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .start_i(start),
        .cfg_sub_chunks_i(cfg_sub),
        .cfg_buf_sel_i(cfg_buf),
        .cfg_clear_i(cfg_clr),
        .cfg_relu_i(cfg_relu),
        .bus(bus),
        .busy_o(busy),
        .done_o(done),
        .protocol_err_o(perr)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int mb [LANES][BUF_NUM];
    int vals [LANES][320];
    int cnt [LANES];
    int st [LANES];
    int cur_buf;
    bit cur_relu;

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    function automatic int sat(input int x);
        if (x > AMAX) return AMAX;
        if (x < AMIN) return AMIN;
        return x;
    endfunction

    function automatic int expect_of(input int lane);
        int e;
        e = mb[lane][cur_buf];
        if (cur_relu && e < 0) e = 0;
        return e;
    endfunction

    task automatic zero_lanes();
        bus.lane_acc_val_i = '0;
        bus.lane_acc_dat_i = '0;
        bus.lane_sub_end_i = '0;
    endtask

    task automatic start_job(input int n, input int b,
                             input bit clr, input bit relu);
        @(negedge clk);
        cfg_sub  = 5'(n);
        cfg_buf  = 2'(b);
        cfg_clr  = clr;
        cfg_relu = relu;
        start    = 1'b1;
        if (clr)
            for (int l = 0; l < LANES; l++) mb[l][b] = 0;
        cur_buf  = b;
        cur_relu = relu;
        @(negedge clk);
        start   = 1'b0;
        cfg_clr = 1'b0;
    endtask

    task automatic wait_pulse();
        int n = 0;
        while (!bus.sub_chunk_start_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("sub_start_pulse", int'(bus.sub_chunk_start_o), 1);
    endtask

    // Lane l sends vals[l][0..cnt-1] on consecutive cycles and ends
    // st[l] cycles after its last value; err_lane sends one late value.
    task automatic run_sub(input int err_lane);
        int k_max = 0;
        bit ended [LANES];
        int v;
        wait_pulse();
        for (int l = 0; l < LANES; l++) begin
            ended[l] = 1'b0;
            if (cnt[l] + st[l] > k_max) k_max = cnt[l] + st[l];
        end
        for (int k = 0; k < k_max; k++) begin
            @(negedge clk);
            if (k == 0)
                chk("pulse_width", int'(bus.sub_chunk_start_o), 0);
            for (int l = 0; l < LANES; l++) begin
                v = 0;
                bus.lane_acc_val_i[l] = 1'b0;
                bus.lane_sub_end_i[l] = 1'b0;
                if (k < cnt[l]) begin
                    v = vals[l][k];
                    bus.lane_acc_val_i[l] = 1'b1;
                    mb[l][cur_buf] = sat(mb[l][cur_buf] + v);
                end else if (l == err_lane && k == k_max - 1 && ended[l]) begin
                    v = 99;
                    bus.lane_acc_val_i[l] = 1'b1;
                end
                if (k == cnt[l] - 1 + st[l]) begin
                    bus.lane_sub_end_i[l] = 1'b1;
                    ended[l] = 1'b1;
                end
                bus.lane_acc_dat_i[l*PROD_W +: PROD_W] = PROD_W'(v);
            end
        end
        @(negedge clk);
        zero_lanes();
    endtask

    task automatic drain(input int stall_at, input int stall_len);
        int b = 0;
        int s = 0;
        int guard = 0;
        bit rdy;
        while (b < LANES && guard < 100) begin
            guard++;
            chk("out_valid", int'(bus.out_valid_o), 1);
            chk("out_lane", int'(bus.out_lane_o), b);
            chk("out_dat", int'($signed(bus.out_dat_o)), expect_of(b));
            chk("done_early", int'(done), 0);
            if (b == stall_at && s < stall_len) begin
                rdy = 1'b0;
                s++;
            end else begin
                rdy = 1'b1;
            end
            bus.out_ready_i = rdy;
            @(negedge clk);
            if (rdy) b++;
        end
        chk("drain_beats", b, LANES);
        bus.out_ready_i = 1'b1;
        chk("done_pulse", int'(done), 1);
        chk("busy_after", int'(busy), 0);
        chk("valid_after", int'(bus.out_valid_o), 0);
        @(negedge clk);
        chk("done_once", int'(done), 0);
        chk("still_idle", int'(busy), 0);
    endtask

    task automatic rand_lanes(input int lo, input int hi, input int smax);
        for (int l = 0; l < LANES; l++) begin
            cnt[l] = int'($urandom_range(1, 6));
            st[l]  = int'($urandom_range(0, smax));
            for (int k = 0; k < cnt[l]; k++)
                vals[l][k] = lo + int'($urandom_range(0, hi - lo));
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_err"}, int'(perr), 0);
        chk({tag, "_valid"}, int'(bus.out_valid_o), 0);
        chk({tag, "_pulse"}, int'(bus.sub_chunk_start_o), 0);
        chk({tag, "_lane"}, int'(bus.out_lane_o), 0);
        chk({tag, "_dat"}, int'(bus.out_dat_o), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        start = 1'b0;
        cfg_sub = '0;
        cfg_buf = '0;
        cfg_clr = 1'b0;
        cfg_relu = 1'b0;
        bus.out_ready_i = 1'b1;
        zero_lanes();
        for (int l = 0; l < LANES; l++)
            for (int b = 0; b < BUF_NUM; b++) mb[l][b] = 0;
        cur_buf = 0;
        cur_relu = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst = 1'b0;

        // T1: one sub-chunk, lane l sends l+1 then -2.
        start_job(1, 0, 1'b1, 1'b0);
        for (int l = 0; l < LANES; l++) begin
            cnt[l] = 2; st[l] = 0;
            vals[l][0] = l + 1; vals[l][1] = -2;
        end
        run_sub(-1);
        drain(-1, 0);
        chk("t1_lane0", mb[0][0], -1);
        chk("t1_no_err", int'(perr), 0);

        // T2 + T4: three staggered sub-chunks, stalled drain.
        start_job(3, 1, 1'b1, 1'b0);
        for (int r = 0; r < 3; r++) begin
            for (int l = 0; l < LANES; l++) begin
                cnt[l] = 1; st[l] = l; vals[l][0] = 5;
            end
            run_sub(-1);
        end
        chk("t2_lane3", mb[3][1], 15);
        drain(2, 5);
        chk("t2_no_err", int'(perr), 0);

        // Random job keeps accumulating on bank 1 without clear.
        start_job(2, 1, 1'b0, 1'b0);
        for (int r = 0; r < 2; r++) begin
            rand_lanes(-127, 127, 3);
            run_sub(-1);
        end
        drain(1, 2);

        // T3: positive saturation, then ReLU.
        start_job(1, 2, 1'b1, 1'b0);
        rand_lanes(-127, 127, 0);
        cnt[0] = 300;
        for (int k = 0; k < 300; k++) vals[0][k] = 127;
        run_sub(-1);
        chk("t3_sat", mb[0][2], AMAX);
        drain(-1, 0);
        start_job(1, 3, 1'b1, 1'b1);
        for (int l = 0; l < LANES; l++) begin
            cnt[l] = 1; st[l] = 0; vals[l][0] = -50;
        end
        run_sub(-1);
        drain(-1, 0);
        start_job(1, 3, 1'b0, 1'b1);
        rand_lanes(-60, 100, 2);
        run_sub(-1);
        drain(3, 1);

        // T5: late value on lane1 is dropped; start while busy ignored.
        chk("t5_err_before", int'(perr), 0);
        start_job(1, 0, 1'b0, 1'b0);
        rand_lanes(-127, 127, 0);
        for (int l = 0; l < LANES; l++) cnt[l] = 1;
        st[3] = 3;
        run_sub(1);
        bus.out_ready_i = 1'b0;
        cfg_clr = 1'b1;
        cfg_buf = 2'd0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cfg_clr = 1'b0;
        chk("t5_err_sticky", int'(perr), 1);
        drain(-1, 0);
        chk("t5_err_kept", int'(perr), 1);

        // T6: reset during RUN, then a fresh job without clear.
        start_job(2, 2, 1'b1, 1'b0);
        wait_pulse();
        @(negedge clk);
        bus.lane_acc_val_i = '1;
        for (int l = 0; l < LANES; l++)
            bus.lane_acc_dat_i[l*PROD_W +: PROD_W] = PROD_W'(10);
        @(negedge clk);
        rst = 1'b1;
        zero_lanes();
        @(negedge clk);
        check_reset_outputs("t6");
        rst = 1'b0;
        for (int l = 0; l < LANES; l++)
            for (int b = 0; b < BUF_NUM; b++) mb[l][b] = 0;
        start_job(0, 2, 1'b0, 1'b0);
        rand_lanes(-127, 127, 3);
        run_sub(-1);
        drain(0, 3);
        chk("t6_no_err", int'(perr), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
